mem_stall_ctrl: RTL
===================

# mem_stall_ctrl

Sequencing controller for the MEM stage when data memory takes more than one cycle. It watches the EX/MEM control bits and runs the request/acknowledge handshake with a multi-cycle data memory. While the access is outstanding it holds a global stall that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It releases the pipeline for exactly one cycle, with read data valid, so MEM/WB captures the result.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, maximum BUSY cycles waiting for mem_ack_i (≥1)

Ports:
- clk_i  in  1  clock; everything updates on posedge
- rst_i  in  1  reset; synchronous, active-high
- mem_read_i  in  1  EX/MEM MemRead
- mem_write_i  in  1  EX/MEM MemWrite
- addr_i  in  ADDR_W  EX/MEM ALU result (address)
- wdata_i  in  DATA_W  EX/MEM store data
- mem_req_o  out  1  request to data memory (registered)
- mem_we_o  out  1  write enable accompanying the request
- mem_addr_o  out  ADDR_W  latched address
- mem_wdata_o  out  DATA_W  latched store data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- stall_o  out  1  freeze all pipeline registers and PC
- rdata_o  out  DATA_W  captured read data, fed to the MEM/WB Data_Memory input
- err_o  out  1  sticky timeout flag
- stall_cnt_o  out  32  stall-cycle counter (see Configuration)

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - access = mem_read_i | mem_write_i.
  - If access: latch addr, wdata and we = mem_write_i; go to BUSY.
  - If both read and write are set, the access is treated as a write.
- BUSY:
  - mem_req_o = 1; address, data and we are held stable.
  - Timeout counter increments every cycle.
  - On mem_ack_i: latch rdata_o = mem_rdata_i for reads (rdata_o unchanged for writes); go to DONE.
  - If the counter reaches TIMEOUT with no ack: rdata_o = 0, err_o = 1; go to DONE.
- DONE:
  - stall_o = 0 and mem_req_o = 0; the pipeline advances one step.
  - Unconditionally go to IDLE.
  - The next instruction's access is evaluated in IDLE; DONE never re-triggers on the instruction that is leaving.
- stall_o = (IDLE & access) | BUSY, forced to 0 while rst_i = 1.
- A mem_ack_i received in IDLE or DONE is ignored.
- err_o is cleared only by rst_i.

## Timing
- Reset values: state IDLE, mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, rdata_o 0, err_o 0, stall_cnt_o 0, timeout counter 0.
- Reset mid-access: the next edge returns to IDLE and mem_req_o drops. Memory must tolerate an abandoned request.
- Access presented in cycle 0:
  - mem_req_o rises at cycle 1.
  - Ack at cycle 1+k (k ≥ 0) gives DONE at cycle 2+k.
  - stall_o is high in cycles 0..1+k.
  - Minimum stall is 2 cycles.
- rdata_o is valid throughout DONE and stays stable until the next read completes.
- Timeout: DONE is entered after exactly TIMEOUT BUSY cycles.
- Back-to-back accesses: at least one DONE cycle (one stall-free cycle) separates them.

## Configuration
- MEM_STALL_CNT_EN defined:
  - stall_cnt_o increments on every cycle stall_o = 1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst_i.
- Not defined: stall_cnt_o is constant 0, and no counter flops are built.

## Structure
- Package mem_ctrl_pkg holds the state encoding (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2) and the default TIMEOUT.
- Sub-module mem_timeout_cnt: clear/enable counter with a terminal-count output, width $clog2(TIMEOUT+1).
- The FSM, latches and stall logic stay in mem_stall_ctrl.

## Test plan
- Load, single-cycle ack:
  - Stimulus: mem_read_i = 1, addr 0x10; ack in the first BUSY cycle with rdata 0xDEADBEEF.
  - Response: stall_o high for 2 cycles; DONE shows rdata_o = 0xDEADBEEF; mem_req_o high for 1 cycle.
- Store, 3-cycle latency:
  - Stimulus: mem_write_i = 1, wdata 0x1234; ack 3 cycles after the request.
  - Response: mem_we_o = 1, mem_wdata_o = 0x1234 held for 3 BUSY cycles; stall_o high for 4 cycles; rdata_o unchanged.
- Back-to-back loads (lw; lw):
  - Response: exactly one stall_o = 0 cycle between the two stall windows; the second mem_addr_o is latched from the new addr_i.
- Timeout:
  - Stimulus: TIMEOUT = 4, no ack.
  - Response: DONE after 4 BUSY cycles; err_o = 1 and stays set; rdata_o = 0.
- Reset mid-BUSY:
  - Stimulus: assert rst_i at the second BUSY cycle.
  - Response: next edge gives IDLE and mem_req_o = 0; stall_o = 0 while rst_i is high.
- MEM_STALL_CNT_EN builds:
  - Stimulus: run the first two scenarios back to back.
  - Response: stall_cnt_o = 6 with the macro defined, 0 without.

Source files
------------

// File: rtl/mem_stall_ctrl_pkg.sv
// Shared definitions for the MEM-stage stall controller: FSM state encoding
// and the default memory timeout.
package mem_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Request/acknowledge bus between the stall controller (master) and the
// multi-cycle data memory (slave).
interface mem_stall_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stall_ctrl_timeout_cnt.sv
// Clear/enable cycle counter; tc_o flags the last permitted BUSY cycle so the
// controller leaves BUSY after exactly TIMEOUT cycles.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i)
            r_cnt <= '0;
        else if (en_i)
            r_cnt <= r_cnt + CW'(1);
    end

    assign tc_o = en_i && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage stall controller: runs the data-memory handshake and freezes the
// pipeline while an access is outstanding. Optional stall counter: MEM_STALL_CNT_EN.
module mem_stall_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    mem_stall_ctrl_if.master  mem,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic [31:0]       stall_cnt_o
);
    state_e            r_state, w_next;
    logic              w_access, w_tc, w_stall;
    logic              r_req, r_we, r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;

    assign w_access = mem_read_i | mem_write_i;

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (r_state != BUSY),
        .en_i  (r_state == BUSY),
        .tc_o  (w_tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // An ack arriving on the terminal BUSY cycle still counts as a completion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_access) w_next = BUSY;
            BUSY:    if (mem.ack || w_tc) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_req <= (w_next == BUSY);
            if (r_state == IDLE && w_access) begin
                r_we    <= mem_write_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
            end
            if (r_state == BUSY) begin
                if (mem.ack) begin
                    if (!r_we)
                        r_rdata <= mem.rdata;
                end else if (w_tc) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign w_stall = !rst_i && (((r_state == IDLE) && w_access) || (r_state == BUSY));

    assign mem.req   = r_req;
    assign mem.we    = r_we;
    assign mem.addr  = r_addr;
    assign mem.wdata = r_wdata;
    assign stall_o   = w_stall;
    assign rdata_o   = r_rdata;
    assign err_o     = r_err;

`ifdef MEM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif
endmodule
